int_issue_sched: RTL and testbench
==================================

INT_ISSUE_SCHED -- requirements
Module: int_issue_sched

Interface
REQ-001 Parameter DEPTH, default 8, number of queue entries (power of two, 2..16).
REQ-002 Parameter UOP_WIDTH, default 67, micro-op width.
REQ-003 Parameter PHY_RF_ADDR_WIDTH, default 7, physical register tag width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 disp_valid_i  in  1  dispatch request.
REQ-007 disp_ready_o  out  1  queue can accept a uop this cycle.
REQ-008 disp_uop_i  in  UOP_WIDTH  integer/control micro-op.
REQ-009 disp_rs1_rdy_i, disp_rs2_rdy_i  in  1 each  source operand already available at dispatch.
REQ-010 wake_valid_i  in  2  per-port result-broadcast valid.
REQ-011 wake_tag_i  in  2*PHY_RF_ADDR_WIDTH  port p tag at bits [p*W +: W].
REQ-012 issue_valid_o  out  1  selected uop available to the ALU.
REQ-013 issue_ready_i  in  1  ALU accepts the issued uop.
REQ-014 issue_uop_o  out  UOP_WIDTH  selected uop, bit-identical to its dispatched value.
REQ-015 flush_i  in  1  discard all queued uops.
REQ-016 illegal_o  out  1  one-cycle pulse: non-int/control uop dropped.
REQ-017 count_o  out  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-018 Uop fields SHALL be: optype [2:0], rd_valid [10], rs1_valid [11], rs2_valid [12], rs1 [27:21], rs2 [34:28]; other bits carried opaquely.
REQ-019 Dispatch handshake SHALL complete when disp_valid_i && disp_ready_o; disp_ready_o = (count_o < DEPTH) && !flush_i, independent of same-cycle issue.
REQ-020 Accepted uop with optype 3'b001 (INT) or 3'b011 (CONT) SHALL be enqueued; any other optype SHALL be dropped and illegal_o asserted the next cycle for one cycle.
REQ-021 Queue SHALL be collapsing: entry 0 oldest; valid entries contiguous from index 0.
REQ-022 Per entry, operand n ready = !rsn_valid || rsn_rdy flag; flag initialised from disp_rsn_rdy_i OR a same-cycle wakeup match on that tag.
REQ-023 Each cycle, any entry flag SHALL be set when a wake_valid_i port tag equals its rsn; both ports act independently; flags never clear except by entry removal.
REQ-024 Wakeup SHALL take effect on registered flags: wake in cycle N makes entry eligible in N+1.
REQ-025 Select SHALL be combinational: lowest-index entry with both operands ready; issue_valid_o high iff such entry exists and !flush_i.
REQ-026 On issue_valid_o && issue_ready_i the selected entry SHALL be removed; entries above shift down one, carrying flags and same-cycle wakeups.
REQ-027 Simultaneous dispatch and issue: count unchanged; new uop written at index count_o-1 after collapse.
REQ-028 Minimum dispatch-to-issue latency SHALL be one cycle (dispatch edge N, issue_valid_o in N+1).
REQ-029 issue_uop_o and issue_valid_o SHALL be stable while issue_valid_o && !issue_ready_i unless an older entry becomes ready.
REQ-030 flush_i SHALL clear all entries at the next edge, count_o=0; same-cycle dispatch and issue ignored.
REQ-031 Full (count_o==DEPTH): disp_ready_o=0; empty: issue_valid_o=0.

Reset
REQ-032 On rst_n low, asynchronously: all entries invalid, flags cleared, count_o=0, issue_valid_o=0, illegal_o=0, disp_ready_o=1 after release.
REQ-033 Reset asserted mid-operation SHALL discard all queued uops with no issue in the reset cycle.

Verification
REQ-034 Dispatch INT uop rs1_valid=1 rs1=5 rdy=0, rs2_valid=0; wake port1 tag 5 two cycles later -> issue_valid_o rises the cycle after wake, uop bit-exact.
REQ-035 Fill 8 ready uops with issue_ready_i=0 -> count_o=8, disp_ready_o=0; raise issue_ready_i -> issued in dispatch order, one per cycle.
REQ-036 Entry 0 waiting on tag 9, entry 1 ready -> entry 1 issues first; wake 9 -> entry 0 issues next.
REQ-037 Full queue, dispatch blocked; issue + new dispatch in a later cycle with count 7 -> count stays 7, new uop at tail.
REQ-038 Dispatch optype 3'b101 -> not enqueued, count_o unchanged, illegal_o one-cycle pulse.
REQ-039 Queue holding 5 uops, flush_i with concurrent dispatch -> count_o=0, issue_valid_o=0 next cycle; rst_n pulse mid-stream -> same.

Source files
------------

// File: rtl/int_issue_sched.sv
// Integer/control issue scheduler: collapsing age-ordered queue with
// wakeup-driven operand readiness and oldest-ready-first select.
module int_issue_sched #(
  parameter int unsigned DEPTH             = 8,
  parameter int unsigned UOP_WIDTH         = 67,
  parameter int unsigned PHY_RF_ADDR_WIDTH = 7
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             disp_valid_i,
  output logic                             disp_ready_o,
  input  logic [UOP_WIDTH-1:0]             disp_uop_i,
  input  logic                             disp_rs1_rdy_i,
  input  logic                             disp_rs2_rdy_i,
  input  logic [1:0]                       wake_valid_i,
  input  logic [2*PHY_RF_ADDR_WIDTH-1:0]   wake_tag_i,
  output logic                             issue_valid_o,
  input  logic                             issue_ready_i,
  output logic [UOP_WIDTH-1:0]             issue_uop_o,
  input  logic                             flush_i,
  output logic                             illegal_o,
  output logic [$clog2(DEPTH):0]           count_o
);

  localparam int unsigned IDX_W     = $clog2(DEPTH);
  localparam int unsigned CNT_W     = IDX_W + 1;
  localparam int unsigned TAG_W     = PHY_RF_ADDR_WIDTH;
  localparam int unsigned RS1_V_BIT = 11;
  localparam int unsigned RS2_V_BIT = 12;
  localparam int unsigned RS1_LSB   = 21;
  localparam int unsigned RS2_LSB   = 28;
  localparam logic [2:0]  OP_INT    = 3'b001;
  localparam logic [2:0]  OP_CONT   = 3'b011;

  // Queue storage; entry 0 is the oldest, valid entries are [0, count_q)
  logic [UOP_WIDTH-1:0] uop_q [DEPTH];
  logic [UOP_WIDTH-1:0] uop_d [DEPTH];
  logic [DEPTH-1:0]     rs1_rdy_q, rs1_rdy_d;
  logic [DEPTH-1:0]     rs2_rdy_q, rs2_rdy_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 illegal_q, illegal_d;

  // Per-entry status
  logic [DEPTH-1:0]     valid_c;
  logic [DEPTH-1:0]     eligible_c;
  logic [DEPTH-1:0]     rs1_fl_c, rs2_fl_c;

  // Select and handshake terms
  logic                 sel_found_c;
  logic [IDX_W-1:0]     sel_idx_c;
  logic                 do_issue_c;
  logic                 disp_fire_c;
  logic                 disp_legal_c;
  logic                 do_enq_c;
  logic [CNT_W-1:0]     count_mid_c;
  logic                 disp_rs1_fl_c, disp_rs2_fl_c;

  // True when either broadcast port carries a matching tag this cycle
  function automatic logic wake_hit(input logic [TAG_W-1:0]   tag,
                                    input logic [1:0]         wv,
                                    input logic [2*TAG_W-1:0] wt);
    wake_hit = (wv[0] && (wt[0 +: TAG_W] == tag)) ||
               (wv[1] && (wt[TAG_W +: TAG_W] == tag));
  endfunction

  // Entry validity, eligibility from registered flags, and flags merged with this cycle's wakeups
  always_comb begin
    valid_c    = '0;
    eligible_c = '0;
    rs1_fl_c   = '0;
    rs2_fl_c   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_c[i]    = CNT_W'(i) < count_q;
      eligible_c[i] = valid_c[i] &&
                      (!uop_q[i][RS1_V_BIT] || rs1_rdy_q[i]) &&
                      (!uop_q[i][RS2_V_BIT] || rs2_rdy_q[i]);
      rs1_fl_c[i]   = rs1_rdy_q[i] ||
                      wake_hit(uop_q[i][RS1_LSB +: TAG_W], wake_valid_i, wake_tag_i);
      rs2_fl_c[i]   = rs2_rdy_q[i] ||
                      wake_hit(uop_q[i][RS2_LSB +: TAG_W], wake_valid_i, wake_tag_i);
    end
  end

  // Oldest-ready select: scanning downward leaves the lowest eligible index
  always_comb begin
    sel_found_c = 1'b0;
    sel_idx_c   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (eligible_c[i]) begin
        sel_found_c = 1'b1;
        sel_idx_c   = IDX_W'(i);
      end
    end
  end

  assign disp_ready_o  = (count_q < CNT_W'(DEPTH)) && !flush_i;
  assign issue_valid_o = sel_found_c && !flush_i;
  assign issue_uop_o   = uop_q[sel_idx_c];
  assign count_o       = count_q;
  assign illegal_o     = illegal_q;

  assign do_issue_c    = issue_valid_o && issue_ready_i;
  assign disp_fire_c   = disp_valid_i && disp_ready_o;
  assign disp_legal_c  = (disp_uop_i[2:0] == OP_INT) || (disp_uop_i[2:0] == OP_CONT);
  assign do_enq_c      = disp_fire_c && disp_legal_c;
  assign count_mid_c   = count_q - CNT_W'(do_issue_c);
  assign disp_rs1_fl_c = disp_rs1_rdy_i ||
                         wake_hit(disp_uop_i[RS1_LSB +: TAG_W], wake_valid_i, wake_tag_i);
  assign disp_rs2_fl_c = disp_rs2_rdy_i ||
                         wake_hit(disp_uop_i[RS2_LSB +: TAG_W], wake_valid_i, wake_tag_i);

  // Next queue state: collapse over the issued slot, append at the tail, flush wins
  always_comb begin
    uop_d     = uop_q;
    rs1_rdy_d = rs1_fl_c;
    rs2_rdy_d = rs2_fl_c;
    count_d   = count_q;
    illegal_d = 1'b0;

    if (do_issue_c) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (IDX_W'(i) >= sel_idx_c) begin
          uop_d[i]     = uop_q[i+1];
          rs1_rdy_d[i] = rs1_fl_c[i+1];
          rs2_rdy_d[i] = rs2_fl_c[i+1];
        end
      end
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (do_enq_c && (CNT_W'(i) == count_mid_c)) begin
        uop_d[i]     = disp_uop_i;
        rs1_rdy_d[i] = disp_rs1_fl_c;
        rs2_rdy_d[i] = disp_rs2_fl_c;
      end
    end

    count_d   = count_mid_c + CNT_W'(do_enq_c);
    illegal_d = disp_fire_c && !disp_legal_c;

    if (flush_i) begin
      count_d   = '0;
      rs1_rdy_d = '0;
      rs2_rdy_d = '0;
      illegal_d = 1'b0;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        uop_q[i] <= '0;
      end
      rs1_rdy_q <= '0;
      rs2_rdy_q <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        uop_q[i] <= uop_d[i];
      end
      rs1_rdy_q <= rs1_rdy_d;
      rs2_rdy_q <= rs2_rdy_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_int_issue_sched.sv
// Directed bench for int_issue_sched: stimulus pushes expected issue order into
// a scoreboard queue; a negedge monitor pops and compares every issue handshake.
module tb_int_issue_sched;

  localparam logic [2:0] OP_INT  = 3'b001;
  localparam logic [2:0] OP_CONT = 3'b011;
  localparam logic [2:0] OP_BAD  = 3'b101;

  logic        clk;
  logic        rst_n;
  logic        disp_valid_i;
  logic        disp_ready_o;
  logic [66:0] disp_uop_i;
  logic        disp_rs1_rdy_i;
  logic        disp_rs2_rdy_i;
  logic [1:0]  wake_valid_i;
  logic [13:0] wake_tag_i;
  logic        issue_valid_o;
  logic        issue_ready_i;
  logic [66:0] issue_uop_o;
  logic        flush_i;
  logic        illegal_o;
  logic [3:0]  count_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [66:0] exp_q[$];
  logic [66:0] exp_uop;

  int_issue_sched #(.DEPTH(8), .UOP_WIDTH(67), .PHY_RF_ADDR_WIDTH(7)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .disp_valid_i   (disp_valid_i),
    .disp_ready_o   (disp_ready_o),
    .disp_uop_i     (disp_uop_i),
    .disp_rs1_rdy_i (disp_rs1_rdy_i),
    .disp_rs2_rdy_i (disp_rs2_rdy_i),
    .wake_valid_i   (wake_valid_i),
    .wake_tag_i     (wake_tag_i),
    .issue_valid_o  (issue_valid_o),
    .issue_ready_i  (issue_ready_i),
    .issue_uop_o    (issue_uop_o),
    .flush_i        (flush_i),
    .illegal_o      (illegal_o),
    .count_o        (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [66:0] mk(input logic [2:0] op, input logic v1, input logic [6:0] t1,
                                     input logic v2, input logic [6:0] t2, input logic [31:0] pad);
    logic [66:0] u;
    u         = '0;
    u[66:35]  = pad;
    u[34:28]  = t2;
    u[27:21]  = t1;
    u[20:13]  = pad[15:8];
    u[12]     = v2;
    u[11]     = v1;
    u[10]     = 1'b1;
    u[9:3]    = pad[6:0];
    u[2:0]    = op;
    return u;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkn(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chku(input string name, input logic [66:0] act, input logic [66:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every completed issue handshake must match the next expected uop
  always @(negedge clk) begin
    if (rst_n && issue_valid_o && issue_ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL issue_unexpected: got %h expected no issue", issue_uop_o);
      end else begin
        exp_uop = exp_q.pop_front();
        chku("issue_uop", issue_uop_o, exp_uop);
      end
    end
  end

  task automatic pedge();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [66:0] u, input logic r1, input logic r2);
    disp_uop_i     = u;
    disp_rs1_rdy_i = r1;
    disp_rs2_rdy_i = r2;
    disp_valid_i   = 1'b1;
    pedge();
    disp_valid_i   = 1'b0;
    disp_rs1_rdy_i = 1'b0;
    disp_rs2_rdy_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    issue_ready_i = 1'b1;
    n = 0;
    while (count_o != 4'd0 && n < 40) begin
      pedge();
      n++;
    end
    chkn(name, count_o, 4'd0);
  endtask

  logic [66:0] u_a, u_d, u_b, u_c, u_n, u_w, u_x, u_f;
  logic [66:0] fill [8];

  initial begin
    rst_n          = 1'b0;
    disp_valid_i   = 1'b0;
    disp_uop_i     = '0;
    disp_rs1_rdy_i = 1'b0;
    disp_rs2_rdy_i = 1'b0;
    wake_valid_i   = 2'b00;
    wake_tag_i     = '0;
    issue_ready_i  = 1'b0;
    flush_i        = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chkn("rst_count", count_o, 4'd0);
    chk1("rst_issue_valid", issue_valid_o, 1'b0);
    chk1("rst_illegal", illegal_o, 1'b0);
    pedge();
    rst_n = 1'b1;
    @(negedge clk);
    chk1("rst_disp_ready", disp_ready_o, 1'b1);
    pedge();

    // Wakeup on port 1 makes a waiting uop eligible the following cycle
    issue_ready_i = 1'b1;
    u_a = mk(OP_INT, 1'b1, 7'd5, 1'b0, 7'd0, 32'hDEAD_BEEF);
    exp_q.push_back(u_a);
    disp(u_a, 1'b0, 1'b0);
    @(negedge clk);
    chkn("wake_count", count_o, 4'd1);
    chk1("wake_wait0", issue_valid_o, 1'b0);
    pedge();
    @(negedge clk);
    chk1("wake_wait1", issue_valid_o, 1'b0);
    pedge();
    wake_valid_i = 2'b10;
    wake_tag_i   = {7'd5, 7'd0};
    @(negedge clk);
    chk1("wake_same_cycle", issue_valid_o, 1'b0);
    pedge();
    wake_valid_i = 2'b00;
    wake_tag_i   = '0;
    @(negedge clk);
    chk1("wake_next_cycle", issue_valid_o, 1'b1);
    pedge();
    @(negedge clk);
    chkn("wake_drained", count_o, 4'd0);

    // Wakeup coincident with dispatch is captured into the new entry
    pedge();
    u_d = mk(OP_CONT, 1'b1, 7'd12, 1'b0, 7'd0, 32'h0000_1234);
    exp_q.push_back(u_d);
    wake_valid_i = 2'b01;
    wake_tag_i   = {7'd0, 7'd12};
    disp(u_d, 1'b0, 1'b0);
    wake_valid_i = 2'b00;
    wake_tag_i   = '0;
    @(negedge clk);
    chk1("disp_wake_issue", issue_valid_o, 1'b1);
    pedge();

    // Fill to capacity with issue stalled, then drain in dispatch order
    issue_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fill[i] = mk((i % 2 == 0) ? OP_INT : OP_CONT, i[0], 7'(i + 40), 1'b0, 7'd0, 32'hA000_0000 + i);
      exp_q.push_back(fill[i]);
      disp(fill[i], 1'b1, 1'b0);
    end
    @(negedge clk);
    chkn("full_count", count_o, 4'd8);
    chk1("full_disp_ready", disp_ready_o, 1'b0);
    chku("full_head_hold", issue_uop_o, fill[0]);
    pedge();
    drain("full_drain");

    // Out-of-order: younger ready entry bypasses older waiting one
    issue_ready_i = 1'b0;
    u_b = mk(OP_INT, 1'b1, 7'd9, 1'b1, 7'd3, 32'h0000_0B0B);
    u_c = mk(OP_INT, 1'b0, 7'd9, 1'b0, 7'd0, 32'h0000_0C0C);
    exp_q.push_back(u_c);
    exp_q.push_back(u_b);
    disp(u_b, 1'b0, 1'b1);
    disp(u_c, 1'b0, 1'b0);
    @(negedge clk);
    chku("ooo_select", issue_uop_o, u_c);
    pedge();
    issue_ready_i = 1'b1;
    pedge();
    wake_valid_i = 2'b01;
    wake_tag_i   = {7'd0, 7'd9};
    @(negedge clk);
    chk1("ooo_waiting", issue_valid_o, 1'b0);
    pedge();
    wake_valid_i = 2'b00;
    wake_tag_i   = '0;
    @(negedge clk);
    chk1("ooo_woken", issue_valid_o, 1'b1);
    pedge();
    @(negedge clk);
    chkn("ooo_drained", count_o, 4'd0);

    // Full queue: blocked dispatch, then issue+dispatch at count 7 keeps count
    issue_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fill[i] = mk(OP_CONT, 1'b0, 7'd0, 1'b1, 7'(i + 60), 32'hB000_0000 + i);
      exp_q.push_back(fill[i]);
      disp(fill[i], 1'b0, 1'b1);
    end
    disp_uop_i   = mk(OP_INT, 1'b0, 7'd0, 1'b0, 7'd0, 32'hBADD_0000);
    disp_valid_i = 1'b1;
    @(negedge clk);
    chk1("blocked_disp_ready", disp_ready_o, 1'b0);
    pedge();
    disp_valid_i  = 1'b0;
    issue_ready_i = 1'b1;
    @(negedge clk);
    chkn("blocked_count", count_o, 4'd8);
    pedge();
    issue_ready_i = 1'b0;
    @(negedge clk);
    chkn("after_issue_count", count_o, 4'd7);
    pedge();
    u_n = mk(OP_INT, 1'b0, 7'd0, 1'b0, 7'd0, 32'hCAFE_0007);
    exp_q.push_back(u_n);
    issue_ready_i = 1'b1;
    disp(u_n, 1'b0, 1'b0);
    issue_ready_i = 1'b0;
    @(negedge clk);
    chkn("simul_count", count_o, 4'd7);
    pedge();
    drain("simul_drain");

    // Illegal optype dropped with a one-cycle pulse
    issue_ready_i = 1'b1;
    u_w = mk(OP_INT, 1'b1, 7'd20, 1'b0, 7'd0, 32'h0000_0020);
    disp(u_w, 1'b0, 1'b0);
    u_x = mk(OP_BAD, 1'b0, 7'd0, 1'b0, 7'd0, 32'h0000_0101);
    disp(u_x, 1'b1, 1'b1);
    @(negedge clk);
    chk1("illegal_pulse", illegal_o, 1'b1);
    chkn("illegal_count", count_o, 4'd1);
    pedge();
    @(negedge clk);
    chk1("illegal_clear", illegal_o, 1'b0);
    pedge();

    // Flush with five queued and a concurrent dispatch
    issue_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(mk(OP_INT, 1'b0, 7'd0, 1'b0, 7'd0, 32'hF000_0000 + i), 1'b0, 1'b0);
    end
    @(negedge clk);
    chkn("pre_flush_count", count_o, 4'd5);
    pedge();
    flush_i       = 1'b1;
    issue_ready_i = 1'b1;
    disp_uop_i    = mk(OP_INT, 1'b0, 7'd0, 1'b0, 7'd0, 32'hF1F1_F1F1);
    disp_valid_i  = 1'b1;
    @(negedge clk);
    chk1("flush_disp_ready", disp_ready_o, 1'b0);
    chk1("flush_issue_valid", issue_valid_o, 1'b0);
    pedge();
    flush_i      = 1'b0;
    disp_valid_i = 1'b0;
    @(negedge clk);
    chkn("post_flush_count", count_o, 4'd0);
    chk1("post_flush_issue_valid", issue_valid_o, 1'b0);
    pedge();

    // Asynchronous reset mid-stream discards queued uops
    issue_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      disp(mk(OP_CONT, 1'b0, 7'd0, 1'b0, 7'd0, 32'hE000_0000 + i), 1'b0, 1'b0);
    end
    rst_n         = 1'b0;
    issue_ready_i = 1'b1;
    @(negedge clk);
    chkn("midrst_count", count_o, 4'd0);
    chk1("midrst_issue_valid", issue_valid_o, 1'b0);
    pedge();
    rst_n = 1'b1;
    @(negedge clk);
    chk1("midrst_disp_ready", disp_ready_o, 1'b1);
    pedge();

    // Minimum latency: dispatched ready uop visible the next cycle
    u_f = mk(OP_INT, 1'b1, 7'd33, 1'b1, 7'd34, 32'h1357_9BDF);
    exp_q.push_back(u_f);
    disp(u_f, 1'b1, 1'b1);
    @(negedge clk);
    chk1("latency_issue_valid", issue_valid_o, 1'b1);
    pedge();
    @(negedge clk);
    chkn("final_count", count_o, 4'd0);
    chkn("scoreboard_empty", 4'(exp_q.size()), 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
